// File: rtl/io_rd_arbiter_pkg.sv
// Shared types and constants for the CPU I/O read arbiter.
// Build option IO_RD_ARB_STATS_EN enables contention statistics.
package io_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD,
        TURN
    } io_arb_state_t;

    localparam logic [7:0] FLOATING_BUS_VAL = 8'hFF;
    localparam logic [7:0] CNT_MAX = 8'hFF;

endpackage

// File: rtl/io_rd_arbiter_if.sv
// CPU read cycle and peripheral read-source bundle.
// master drives requests and source data; slave is the arbiter.
interface io_rd_arbiter_if #(
    parameter int NSRC = 4
);
    logic              ioreq;
    logic              rd;
    logic              m1;
    logic [NSRC-1:0]   src_active;
    logic [NSRC*8-1:0] src_data;
    logic [7:0]        d_out;
    logic              d_out_oe;
    logic [NSRC-1:0]   rd_grant;
    logic              contention;
    logic [7:0]        contention_cnt;

    modport master (
        output ioreq,
        output rd,
        output m1,
        output src_active,
        output src_data,
        input  d_out,
        input  d_out_oe,
        input  rd_grant,
        input  contention,
        input  contention_cnt
    );

    modport slave (
        input  ioreq,
        input  rd,
        input  m1,
        input  src_active,
        input  src_data,
        output d_out,
        output d_out_oe,
        output rd_grant,
        output contention,
        output contention_cnt
    );
endinterface

// File: rtl/io_rd_arbiter_prio_pick.sv
// Fixed-priority picker: lowest active index wins.
// multi is only computed when IO_RD_ARB_STATS_EN is defined.
module io_prio_pick #(
    parameter int NSRC = 4
) (
    input  logic [NSRC-1:0] src_active,
    output logic [NSRC-1:0] grant,
    output logic            any,
    output logic            multi
);

    // x & -x isolates the lowest set bit
    always_comb begin
        grant = src_active & (~src_active + NSRC'(1));
        any   = |src_active;
    end

`ifdef IO_RD_ARB_STATS_EN
    always_comb begin
        multi = |(src_active & (src_active - NSRC'(1)));
    end
`else
    always_comb begin
        multi = 1'b0;
    end
`endif

endmodule

// File: rtl/io_rd_arbiter.sv
// CPU I/O read arbiter: settle, fixed-priority latch, hold, turnaround.
// Contention statistics are built only with IO_RD_ARB_STATS_EN.
module io_rd_arbiter
    import io_rd_arbiter_pkg::*;
#(
    parameter int NSRC   = 4,
    parameter int SETTLE = 2
) (
    input  logic              clk28,
    input  logic              rst_n,
    io_rd_arbiter_if.slave    bus
);

    localparam logic [2:0] SETTLE_M1 = 3'(SETTLE - 1);

    io_arb_state_t   state;
    logic [2:0]      cnt;
    logic [7:0]      d_out;
    logic            d_out_oe;
    logic [NSRC-1:0] rd_grant;

    logic [NSRC-1:0] grant;
    logic            any;
    logic            multi;
    logic [7:0]      sel_data;
    logic            req;
    logic            latch_now;

    io_prio_pick #(
        .NSRC (NSRC)
    ) u_pick (
        .src_active (bus.src_active),
        .grant      (grant),
        .any        (any),
        .multi      (multi)
    );

    always_comb begin
        sel_data = 8'h00;
        for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) sel_data = sel_data | bus.src_data[8*i +: 8];
        end
        if (!any) sel_data = FLOATING_BUS_VAL;
    end

    always_comb begin
        req       = bus.ioreq && bus.rd && !bus.m1;
        latch_now = (state == WAIT) && req && (cnt == 3'd0);
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            d_out    <= FLOATING_BUS_VAL;
            d_out_oe <= 1'b0;
            rd_grant <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        state <= WAIT;
                        cnt   <= SETTLE_M1;
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state <= IDLE;
                    end else if (latch_now) begin
                        state    <= HOLD;
                        rd_grant <= grant;
                        d_out    <= sel_data;
                        d_out_oe <= any;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                HOLD: begin
                    if (!req) begin
                        state    <= TURN;
                        d_out_oe <= 1'b0;
                        rd_grant <= '0;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef IO_RD_ARB_STATS_EN
    logic       contention;
    logic [7:0] contention_cnt;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            contention     <= 1'b0;
            contention_cnt <= 8'h00;
        end else begin
            contention <= latch_now && multi;
            if (latch_now && multi && contention_cnt != CNT_MAX)
                contention_cnt <= contention_cnt + 8'd1;
        end
    end

    assign bus.contention     = contention;
    assign bus.contention_cnt = contention_cnt;
`else
    // picker drives multi low in this build
    assign bus.contention     = multi;
    assign bus.contention_cnt = 8'h00;
`endif

    assign bus.d_out    = d_out;
    assign bus.d_out_oe = d_out_oe;
    assign bus.rd_grant = rd_grant;

endmodule

// File: tb/tb_io_rd_arbiter.sv
// Directed bench for io_rd_arbiter (NSRC=4, SETTLE=2).
// Statistics expectations follow IO_RD_ARB_STATS_EN.
module tb_io_rd_arbiter;

`ifdef IO_RD_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk28 = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_cnt = 8'h00;

    always #5 clk28 = ~clk28;

    io_rd_arbiter_if #(.NSRC(4)) bus ();

    io_rd_arbiter #(
        .NSRC   (4),
        .SETTLE (2)
    ) dut (
        .clk28 (clk28),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk28);
        #1;
    endtask

    task automatic set_req(input logic v);
        bus.ioreq = v;
        bus.rd    = v;
    endtask

    task automatic end_cycle();
        set_req(1'b0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_req(1'b0);
        bus.m1         = 1'b0;
        bus.src_active = 4'b0000;
        bus.src_data   = 32'h0;
        #12;
        checks++;
        if (bus.d_out !== 8'hFF) begin
            errors++;
            $display("FAIL reset_d_out got %h want ff", bus.d_out);
        end
        checks++;
        if (bus.d_out_oe !== 1'b0 || bus.rd_grant !== 4'b0000) begin
            errors++;
            $display("FAIL reset_oe_grant got %b/%b want 0/0000",
                     bus.d_out_oe, bus.rd_grant);
        end
        checks++;
        if (bus.contention !== 1'b0 || bus.contention_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_stats got %b/%h want 0/00",
                     bus.contention, bus.contention_cnt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.src_active = 4'b0010;
        bus.src_data   = 32'h0000_A500;
        set_req(1'b1);
        tick();
        tick();
        checks++;
        if (bus.d_out_oe !== 1'b0) begin
            errors++;
            $display("FAIL single_early_oe got %b want 0", bus.d_out_oe);
        end
        tick();
        checks++;
        if (bus.d_out !== 8'hA5 || bus.d_out_oe !== 1'b1) begin
            errors++;
            $display("FAIL single_data got %h/%b want a5/1",
                     bus.d_out, bus.d_out_oe);
        end
        checks++;
        if (bus.rd_grant !== 4'b0010 || bus.contention !== 1'b0) begin
            errors++;
            $display("FAIL single_grant got %b/%b want 0010/0",
                     bus.rd_grant, bus.contention);
        end
    endtask

    task automatic test_freeze_turn();
        bus.src_data = 32'h0000_5A00;
        tick();
        tick();
        checks++;
        if (bus.d_out !== 8'hA5) begin
            errors++;
            $display("FAIL freeze_d_out got %h want a5", bus.d_out);
        end
        bus.rd = 1'b0;
        tick();
        checks++;
        if (bus.d_out_oe !== 1'b0 || bus.rd_grant !== 4'b0000 ||
            bus.d_out !== 8'hA5) begin
            errors++;
            $display("FAIL turn_drop got %b/%b/%h want 0/0000/a5",
                     bus.d_out_oe, bus.rd_grant, bus.d_out);
        end
        bus.rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.d_out_oe !== 1'b0) begin
                errors++;
                $display("FAIL turn_gap%0d got oe %b want 0", i, bus.d_out_oe);
            end
        end
        tick();
        checks++;
        if (bus.d_out_oe !== 1'b1 || bus.d_out !== 8'h5A) begin
            errors++;
            $display("FAIL turn_regrant got %b/%h want 1/5a",
                     bus.d_out_oe, bus.d_out);
        end
        end_cycle();
    endtask

    task automatic test_no_source();
        bus.src_active = 4'b0000;
        set_req(1'b1);
        tick();
        tick();
        tick();
        checks++;
        if (bus.d_out !== 8'hFF || bus.d_out_oe !== 1'b0 ||
            bus.rd_grant !== 4'b0000) begin
            errors++;
            $display("FAIL no_source got %h/%b/%b want ff/0/0000",
                     bus.d_out, bus.d_out_oe, bus.rd_grant);
        end
        end_cycle();
    endtask

    task automatic test_m1();
        bus.src_active = 4'b0010;
        bus.src_data   = 32'h0000_3C00;
        bus.m1         = 1'b1;
        set_req(1'b1);
        repeat (5) tick();
        checks++;
        if (bus.d_out_oe !== 1'b0 || bus.d_out !== 8'hFF) begin
            errors++;
            $display("FAIL m1_ignored got %b/%h want 0/ff",
                     bus.d_out_oe, bus.d_out);
        end
        bus.m1 = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.d_out_oe !== 1'b0) begin
            errors++;
            $display("FAIL m1_idle_latency got %b want 0", bus.d_out_oe);
        end
        tick();
        checks++;
        if (bus.d_out_oe !== 1'b1 || bus.d_out !== 8'h3C) begin
            errors++;
            $display("FAIL m1_after got %b/%h want 1/3c",
                     bus.d_out_oe, bus.d_out);
        end
        end_cycle();
    endtask

    task automatic test_contention();
        bus.src_active = 4'b0110;
        bus.src_data   = 32'h0022_1100;
        set_req(1'b1);
        tick();
        tick();
        tick();
        if (STATS) exp_cnt = 8'd1;
        checks++;
        if (bus.d_out !== 8'h11 || bus.rd_grant !== 4'b0010) begin
            errors++;
            $display("FAIL cont_pick got %h/%b want 11/0010",
                     bus.d_out, bus.rd_grant);
        end
        checks++;
        if (bus.contention !== STATS || bus.contention_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL cont_pulse got %b/%h want %b/%h",
                     bus.contention, bus.contention_cnt, STATS, exp_cnt);
        end
        tick();
        checks++;
        if (bus.contention !== 1'b0) begin
            errors++;
            $display("FAIL cont_one_clk got %b want 0", bus.contention);
        end
        end_cycle();
    endtask

    task automatic test_abort();
        set_req(1'b1);
        tick();
        set_req(1'b0);
        repeat (3) tick();
        checks++;
        if (bus.d_out_oe !== 1'b0 || bus.contention_cnt !== exp_cnt ||
            bus.d_out !== 8'h11) begin
            errors++;
            $display("FAIL abort got %b/%h/%h want 0/%h/11",
                     bus.d_out_oe, bus.contention_cnt, bus.d_out, exp_cnt);
        end
    endtask

    task automatic test_saturate();
        for (int i = 1; i < 300; i++) begin
            set_req(1'b1);
            repeat (3) tick();
            end_cycle();
        end
        if (STATS) exp_cnt = 8'd255;
        checks++;
        if (bus.contention_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL saturate got %h want %h",
                     bus.contention_cnt, exp_cnt);
        end
    endtask

    task automatic test_async_reset();
        bus.src_active = 4'b0010;
        bus.src_data   = 32'h0000_A500;
        set_req(1'b1);
        repeat (3) tick();
        checks++;
        if (bus.d_out_oe !== 1'b1) begin
            errors++;
            $display("FAIL arst_setup got oe %b want 1", bus.d_out_oe);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.d_out_oe !== 1'b0 || bus.d_out !== 8'hFF ||
            bus.contention_cnt !== 8'h00 || bus.rd_grant !== 4'b0000) begin
            errors++;
            $display("FAIL arst got %b/%h/%h/%b want 0/ff/00/0000",
                     bus.d_out_oe, bus.d_out, bus.contention_cnt,
                     bus.rd_grant);
        end
        set_req(1'b0);
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.d_out_oe !== 1'b0) begin
            errors++;
            $display("FAIL arst_release got %b want 0", bus.d_out_oe);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_freeze_turn();
        test_no_source();
        test_m1();
        test_contention();
        test_abort();
        test_saturate();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
